// File: rtl/nn_batch_scheduler.sv
// nn_batch_scheduler
// Batch-inference controller for the neural-network top level. Walks a
// sample address through a test-vector ROM and runs N_LAYERS layer passes
// per sample over a start/ready handshake with the neuron datapath. It then
// takes the argmax of the streamed class scores, scores the prediction
// against the ROM label, and strobes at batch and run boundaries.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous reset, active-low (0 = reset)
//   start          run request, honoured only in IDLE/DONE
//   sample_addr    ROM address of the current sample
//   layer_sel      current layer index (0..N_LAYERS-1)
//   neuron_start   one-cycle pulse launching a layer pass
//   neuron_ready   datapath finished the current layer pass
//   score_valid    qualifies score
//   score          signed class score, classes in index order
//   label          expected class for sample_addr (combinational ROM)
//   pred_class     argmax of the last completed sample
//   pred_valid     one-cycle pulse, pred_class updated
//   correct_count  correct predictions in this run
//   batch_done     one-cycle pulse at the end of each (possibly partial) batch
//   busy           high in every state except IDLE/DONE
//   done           level, high in DONE
module nn_batch_scheduler #(
  parameter int N_SAMPLES = 750,
  parameter int BATCH     = 50,
  parameter int N_LAYERS  = 2,
  parameter int N_CLASSES = 10,
  parameter int SCORE_W   = 16,
  parameter int ADDR_W    = 10,
  parameter int CLASS_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic [ADDR_W-1:0]         sample_addr,
  output logic [1:0]                layer_sel,
  output logic                      neuron_start,
  input  logic                      neuron_ready,
  input  logic                      score_valid,
  input  logic signed [SCORE_W-1:0] score,
  input  logic [CLASS_W-1:0]        label,
  output logic [CLASS_W-1:0]        pred_class,
  output logic                      pred_valid,
  output logic [ADDR_W:0]           correct_count,
  output logic                      batch_done,
  output logic                      busy,
  output logic                      done
);

  localparam int BATCH_W = (BATCH > 1) ? $clog2(BATCH) : 1;

  typedef enum logic [2:0] {
    IDLE, LSTART, LWAIT, SCORE, DECIDE, NEXT, DONE
  } state_t;

  state_t                     state;
  logic [CLASS_W-1:0]         class_cnt;
  logic signed [SCORE_W-1:0]  best;
  logic [CLASS_W-1:0]         best_idx;
  // Position inside the current batch; avoids a modulo on sample_addr.
  logic [BATCH_W-1:0]         batch_cnt;

  logic               take_new;
  logic [CLASS_W-1:0] new_idx;
  logic               last_class;
  logic               last_sample;
  logic               last_layer;
  logic               batch_end;

  // Running-max update including the score arriving this cycle, so the final
  // argmax is ready on the edge that accepts the last score. Strict '>' keeps
  // the lower index on ties.
  assign take_new    = (class_cnt == '0) || (score > best);
  assign new_idx     = take_new ? class_cnt : best_idx;
  assign last_class  = (class_cnt == CLASS_W'(N_CLASSES - 1));
  assign last_sample = (sample_addr == ADDR_W'(N_SAMPLES - 1));
  assign last_layer  = (layer_sel == 2'(N_LAYERS - 1));
  assign batch_end   = (batch_cnt == BATCH_W'(BATCH - 1));

  // Single control FSM; all outputs are registered. Strobes default low each
  // cycle and are raised on the transition into the state that owns them, so
  // neuron_start is high during LSTART and pred_valid/batch_done during DECIDE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      sample_addr   <= '0;
      layer_sel     <= '0;
      neuron_start  <= 1'b0;
      pred_class    <= '0;
      pred_valid    <= 1'b0;
      correct_count <= '0;
      batch_done    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      class_cnt     <= '0;
      best          <= '0;
      best_idx      <= '0;
      batch_cnt     <= '0;
    end else begin
      neuron_start <= 1'b0;
      pred_valid   <= 1'b0;
      batch_done   <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sample_addr   <= '0;
            layer_sel     <= '0;
            correct_count <= '0;
            batch_cnt     <= '0;
            done          <= 1'b0;
            busy          <= 1'b1;
            neuron_start  <= 1'b1;
            state         <= LSTART;
          end
        end
        LSTART: state <= LWAIT;
        LWAIT: begin
          if (neuron_ready) begin
            if (!last_layer) begin
              layer_sel    <= layer_sel + 2'd1;
              neuron_start <= 1'b1;
              state        <= LSTART;
            end else begin
              class_cnt <= '0;
              state     <= SCORE;
            end
          end
        end
        SCORE: begin
          if (score_valid) begin
            if (take_new) begin
              best     <= score;
              best_idx <= class_cnt;
            end
            class_cnt <= class_cnt + 1'b1;
            // sample_addr does not move until NEXT, so the label seen here
            // is the same one presented throughout DECIDE.
            if (last_class) begin
              pred_class    <= new_idx;
              pred_valid    <= 1'b1;
              correct_count <= correct_count + ((new_idx == label) ? (ADDR_W+1)'(1) : '0);
              batch_done    <= batch_end || last_sample;
              state         <= DECIDE;
            end
          end
        end
        DECIDE: begin
          if (last_sample) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            state <= NEXT;
          end
        end
        NEXT: begin
          sample_addr  <= sample_addr + 1'b1;
          layer_sel    <= '0;
          batch_cnt    <= batch_end ? '0 : batch_cnt + 1'b1;
          neuron_start <= 1'b1;
          state        <= LSTART;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_batch_scheduler.sv
// tb_nn_batch_scheduler
// Self-checking bench for nn_batch_scheduler with a small configuration
// (5 samples, batches of 2, 2 layers, 3 classes). The bench plays the neuron
// datapath and the label ROM, injects random wait states and spurious inputs,
// and checks every prediction against an argmax reference model.
module tb_nn_batch_scheduler;

  localparam int NS = 5;
  localparam int BT = 2;
  localparam int NL = 2;
  localparam int NC = 3;
  localparam int SW = 16;
  localparam int AW = 10;
  localparam int CW = 4;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic [AW-1:0]        sample_addr;
  logic [1:0]           layer_sel;
  logic                 neuron_start;
  logic                 neuron_ready;
  logic                 score_valid;
  logic signed [SW-1:0] score;
  logic [CW-1:0]        label;
  logic [CW-1:0]        pred_class;
  logic                 pred_valid;
  logic [AW:0]          correct_count;
  logic                 batch_done;
  logic                 busy;
  logic                 done;

  int sc [NS][NC];
  logic [CW-1:0] label_rom [NS];

  int err_count = 0;
  int chk_count = 0;
  int ns_pulses = 0;
  int pv_pulses = 0;
  int bd_pulses = 0;

  nn_batch_scheduler #(
    .N_SAMPLES(NS), .BATCH(BT), .N_LAYERS(NL), .N_CLASSES(NC),
    .SCORE_W(SW), .ADDR_W(AW), .CLASS_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .sample_addr(sample_addr), .layer_sel(layer_sel),
    .neuron_start(neuron_start), .neuron_ready(neuron_ready),
    .score_valid(score_valid), .score(score), .label(label),
    .pred_class(pred_class), .pred_valid(pred_valid),
    .correct_count(correct_count), .batch_done(batch_done),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational label ROM addressed by the DUT.
  always_comb begin
    label = '0;
    if (sample_addr < AW'(NS)) label = label_rom[sample_addr[2:0]];
  end

  // Strobe counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (neuron_start) ns_pulses++;
      if (pred_valid)   pv_pulses++;
      if (batch_done)   bd_pulses++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_count++;
    if (got !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference argmax: first index holding the maximum score.
  function automatic int ref_argmax(input int s);
    int b = 0;
    for (int k = 1; k < NC; k++)
      if (sc[s][k] > sc[s][b]) b = k;
    return b;
  endfunction

  function automatic bit ref_batch_end(input int s);
    return ((s + 1) % BT == 0) || (s == NS - 1);
  endfunction

  task automatic gen_vectors(input bit directed);
    for (int s = 0; s < NS; s++) begin
      for (int k = 0; k < NC; k++) sc[s][k] = int'($urandom_range(0, 40)) - 20;
      label_rom[s] = CW'($urandom_range(0, NC - 1));
    end
    if (directed) begin
      sc[0][0] = -5; sc[0][1] = 7;  sc[0][2] = 7;  label_rom[0] = 4'd1;
      sc[1][0] = -3; sc[1][1] = -2; sc[1][2] = -9; label_rom[1] = 4'd0;
    end
  endtask

  task automatic wait_neuron_start();
    int n = 0;
    while (neuron_start !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkOutput("neuron_start_seen", 32'(neuron_start), 32'd1);
  endtask

  task automatic check_all_zero();
    checkOutput("rst_sample_addr", 32'(sample_addr), 32'd0);
    checkOutput("rst_layer_sel", 32'(layer_sel), 32'd0);
    checkOutput("rst_pred_class", 32'(pred_class), 32'd0);
    checkOutput("rst_correct_count", 32'(correct_count), 32'd0);
    checkOutput("rst_strobes", {28'd0, neuron_start, pred_valid, batch_done, busy}, 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
  endtask

  // One full run from start; abort_s >= 0 asserts reset during the score
  // phase of that sample and returns.
  task automatic applyStimulus(input int abort_s);
    int base_ns = ns_pulses;
    int base_pv = pv_pulses;
    int base_bd = bd_pulses;
    int exp_cnt = 0;
    int exp_bd  = 0;
    int exp_p;
    int d;
    int g;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("run_done_clr", 32'(done), 32'd0);
    checkOutput("run_cnt_clr", 32'(correct_count), 32'd0);
    checkOutput("run_busy", 32'(busy), 32'd1);
    for (int s = 0; s < NS; s++) begin
      for (int l = 0; l < NL; l++) begin
        wait_neuron_start();
        checkOutput("layer_sel", 32'(layer_sel), 32'(l));
        checkOutput("sample_addr", 32'(sample_addr), 32'(s));
        tick();
        d = int'($urandom_range(0, 2));
        for (int i = 0; i < d; i++) begin
          score_valid = 1'($urandom_range(0, 1));
          score       = SW'($urandom);
          start       = 1'($urandom_range(0, 1));
          tick();
        end
        score_valid  = 1'b0;
        start        = 1'b0;
        neuron_ready = 1'b1;
        tick();
        neuron_ready = 1'b0;
      end
      for (int k = 0; k < NC; k++) begin
        g = int'($urandom_range(0, 2));
        for (int i = 0; i < g; i++) begin
          neuron_ready = 1'($urandom_range(0, 1));
          start        = 1'($urandom_range(0, 1));
          score        = SW'($urandom);
          tick();
        end
        neuron_ready = 1'b0;
        start        = 1'b0;
        if (s == abort_s && k == 1) begin
          #2 rst = 1'b0;
          #1 check_all_zero();
          #3 rst = 1'b1;
          tick();
          return;
        end
        score_valid = 1'b1;
        score       = SW'(sc[s][k]);
        tick();
        score_valid = 1'b0;
      end
      exp_p = ref_argmax(s);
      if (exp_p == int'(label_rom[s])) exp_cnt++;
      if (ref_batch_end(s)) exp_bd++;
      checkOutput("pred_valid", 32'(pred_valid), 32'd1);
      checkOutput("pred_class", 32'(pred_class), 32'(exp_p));
      checkOutput("correct_count", 32'(correct_count), 32'(exp_cnt));
      checkOutput("batch_done", 32'(batch_done), 32'(ref_batch_end(s)));
      tick();
      checkOutput("pred_valid_pulse", 32'(pred_valid), 32'd0);
      if (s == NS - 1) begin
        checkOutput("done_rise", 32'(done), 32'd1);
        checkOutput("busy_fall", 32'(busy), 32'd0);
      end
    end
    checkOutput("neuron_start_count", 32'(ns_pulses - base_ns), 32'(NS * NL));
    checkOutput("pred_valid_count", 32'(pv_pulses - base_pv), 32'(NS));
    checkOutput("batch_done_count", 32'(bd_pulses - base_bd), 32'(exp_bd));
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    neuron_ready = 1'b0;
    score_valid  = 1'b0;
    score        = '0;
    for (int s = 0; s < NS; s++) label_rom[s] = '0;
    #2 rst = 1'b0;
    #1 check_all_zero();
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check_all_zero();

    $display("[TB] run 1: directed tie/mismatch samples plus random");
    gen_vectors(1'b1);
    applyStimulus(-1);
    repeat (3) tick();
    checkOutput("done_held", 32'(done), 32'd1);
    checkOutput("count_held", 32'(correct_count), 32'd1 + 32'(ref_argmax(2) == int'(label_rom[2]))
                + 32'(ref_argmax(3) == int'(label_rom[3])) + 32'(ref_argmax(4) == int'(label_rom[4])));

    $display("[TB] run 2: restart from DONE with identical stimulus");
    applyStimulus(-1);

    $display("[TB] run 3: reset during score phase of sample 2");
    gen_vectors(1'b0);
    applyStimulus(2);
    check_all_zero();

    $display("[TB] run 4: fresh run after reset");
    applyStimulus(-1);

    $display("Result: errors=%0d of %0d checks", err_count, chk_count);
    $finish;
  end

endmodule
